ifu_br_resolver: RTL and testbench

Fetch-side consumer of the execute-response channel driven by the EXU branch handler. It accepts resolved branch/jump packets, issues a fetch redirect on every misprediction, and trains a direct-mapped BTB with 2-bit saturating direction counters. It also serves the fetch stage's same-cycle prediction lookup. It sits in the IFU between the EXU response port and the PC-select logic.

---
 rtl/ifu_br_resolver_if.sv | 19 +
 rtl/ifu_br_resolver.sv | 178 +++++++++++++++++
 tb/tb_ifu_br_resolver.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_br_resolver_if.sv
// Execute-response channel from the EXU branch handler: one resolved
// control-transfer packet per vld/rdy handshake.
interface ex_rsp_if_t #(
  parameter int RV_PC_SIZE = 32
);
  typedef struct packed {
    logic [RV_PC_SIZE-1:0] pc;
    logic [RV_PC_SIZE-1:0] target_pc;
    logic                  taken;
    logic                  pred_true;
  } ex_rsp_pkt_t;

  logic        vld;
  logic        rdy;
  ex_rsp_pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/ifu_br_resolver.sv
// IFU branch resolver: redirects fetch on mispredictions, trains a direct-mapped
// BTB with 2-bit direction counters, and serves the same-cycle fetch lookup.
module ifu_br_resolver #(
  parameter int BTB_ENTRIES = 16,
  parameter int RV_PC_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_rsp_if_t.slv               ex_rsp_slv,
  output logic                  redir_vld,
  input  logic                  redir_rdy,
  output logic [RV_PC_SIZE-1:0] redir_pc,
  input  logic [RV_PC_SIZE-1:0] lk_pc,
  output logic                  lk_taken,
  output logic [RV_PC_SIZE-1:0] lk_target,
  output logic [31:0]           br_cnt,
  output logic [31:0]           mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = RV_PC_SIZE - IDX_W - 2;
  localparam logic [RV_PC_SIZE-1:0] PC_STEP = RV_PC_SIZE'(3'd4);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    acc_s;
  logic                    mispred_s;
  logic [RV_PC_SIZE-1:0]   redir_pc_r;

  logic                    upd_vld_r;
  logic [IDX_W-1:0]        upd_idx_r;
  logic [TAG_W-1:0]        upd_tag_r;
  logic                    upd_taken_r;
  logic [RV_PC_SIZE-1:0]   upd_target_r;
  logic                    upd_hit_s;

  logic [BTB_ENTRIES-1:0]  valid_r;
  logic [TAG_W-1:0]        tag_r    [BTB_ENTRIES];
  logic [RV_PC_SIZE-1:0]   target_r [BTB_ENTRIES];
  logic [1:0]              ctr_r    [BTB_ENTRIES];

  logic [IDX_W-1:0]        lk_idx_s;
  logic [TAG_W-1:0]        lk_tag_s;
  logic                    lk_hit_s;

  logic [31:0]             br_cnt_r;
  logic [31:0]             mispred_cnt_r;

  assign ex_rsp_slv.rdy = (state_r == ST_IDLE);
  assign acc_s          = ex_rsp_slv.vld & (state_r == ST_IDLE);
  assign mispred_s      = acc_s & ~ex_rsp_slv.pkt.pred_true;
  assign redir_vld      = (state_r == ST_REDIR);
  assign redir_pc       = redir_pc_r;
  assign br_cnt         = br_cnt_r;
  assign mispred_cnt    = mispred_cnt_r;
  assign upd_hit_s      = valid_r[upd_idx_r] & (tag_r[upd_idx_r] == upd_tag_r);

  // Redirect FSM next-state: park in REDIR until fetch takes the new PC.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mispred_s) state_nxt_s = ST_REDIR;
        else           state_nxt_s = ST_IDLE;
      end
      ST_REDIR: begin
        if (redir_rdy) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_REDIR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Redirect FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Redirect target is the EXU-resolved next PC, held until the handshake.
  always_ff @(posedge clk) begin
    if (rst)            redir_pc_r <= {RV_PC_SIZE{1'b0}};
    else if (mispred_s) redir_pc_r <= ex_rsp_slv.pkt.target_pc;
    else                redir_pc_r <= redir_pc_r;
  end

  // One-deep update register; overwritten on every accept, never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_vld_r    <= 1'b0;
      upd_idx_r    <= {IDX_W{1'b0}};
      upd_tag_r    <= {TAG_W{1'b0}};
      upd_taken_r  <= 1'b0;
      upd_target_r <= {RV_PC_SIZE{1'b0}};
    end else begin
      upd_vld_r <= acc_s;
      if (acc_s) begin
        upd_idx_r    <= ex_rsp_slv.pkt.pc[IDX_W+1:2];
        upd_tag_r    <= ex_rsp_slv.pkt.pc[RV_PC_SIZE-1:IDX_W+2];
        upd_taken_r  <= ex_rsp_slv.pkt.taken;
        upd_target_r <= ex_rsp_slv.pkt.target_pc;
      end else begin
        upd_idx_r    <= upd_idx_r;
        upd_tag_r    <= upd_tag_r;
        upd_taken_r  <= upd_taken_r;
        upd_target_r <= upd_target_r;
      end
    end
  end

  // BTB/BHT training: taken allocates or strengthens, not-taken weakens on hit only.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {BTB_ENTRIES{1'b0}};
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {RV_PC_SIZE{1'b0}};
        ctr_r[i]    <= 2'b01;
      end
    end else if (upd_vld_r) begin
      if (upd_taken_r) begin
        valid_r[upd_idx_r]  <= 1'b1;
        tag_r[upd_idx_r]    <= upd_tag_r;
        target_r[upd_idx_r] <= upd_target_r;
        ctr_r[upd_idx_r]    <= upd_hit_s ? ctr_inc(ctr_r[upd_idx_r]) : 2'b10;
      end else if (upd_hit_s) begin
        ctr_r[upd_idx_r] <= ctr_dec(ctr_r[upd_idx_r]);
      end else begin
        ctr_r[upd_idx_r] <= ctr_r[upd_idx_r];
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  // Resolved-transfer and misprediction counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_r      <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      br_cnt_r      <= acc_s ? br_cnt_r + 32'd1 : br_cnt_r;
      mispred_cnt_r <= mispred_s ? mispred_cnt_r + 32'd1 : mispred_cnt_r;
    end
  end

  // Same-cycle prediction; reads the pre-write table contents.
  always_comb begin
    lk_idx_s  = lk_pc[IDX_W+1:2];
    lk_tag_s  = lk_pc[RV_PC_SIZE-1:IDX_W+2];
    lk_hit_s  = 1'b0;
    lk_taken  = 1'b0;
    lk_target = lk_pc + PC_STEP;
    if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) lk_hit_s = 1'b1;
    else                                                    lk_hit_s = 1'b0;
    if (lk_hit_s && ctr_r[lk_idx_s][1]) begin
      lk_taken  = 1'b1;
      lk_target = target_r[lk_idx_s];
    end else begin
      lk_taken  = 1'b0;
      lk_target = lk_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_ifu_br_resolver.sv
// Directed plus randomized bench for ifu_br_resolver against an array-based
// reference model of the BTB, redirect handshake and counters.
module tb_ifu_br_resolver;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_vld;
  logic        redir_rdy;
  logic [31:0] redir_pc;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  always #5 clk = ~clk;

  ex_rsp_if_t #(.RV_PC_SIZE(32)) ex_if ();

  ifu_br_resolver #(.BTB_ENTRIES(N), .RV_PC_SIZE(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_rsp_slv  (ex_if),
    .redir_vld   (redir_vld),
    .redir_rdy   (redir_rdy),
    .redir_pc    (redir_pc),
    .lk_pc       (lk_pc),
    .lk_taken    (lk_taken),
    .lk_target   (lk_target),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_redir;
  logic [31:0] m_redir_pc;
  bit          m_upd;
  logic [31:0] m_upd_pc;
  logic [31:0] m_upd_tgt;
  bit          m_upd_taken;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (32'd4 * N);
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    if (exp_taken(pc)) return m_tgt[idx_of(pc)];
    return pc + 32'd4;
  endfunction

  task automatic model_edge();
    bit acc;
    int i;
    bit hit;
    if (rst) begin
      m_redir = 0; m_redir_pc = 32'd0; m_upd = 0; m_br = 32'd0; m_mis = 32'd0;
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 0; m_tag[k] = 32'd0; m_tgt[k] = 32'd0; m_ctr[k] = 1;
      end
    end else begin
      acc = ex_if.vld && !m_redir;
      if (m_upd) begin
        i   = idx_of(m_upd_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(m_upd_pc));
        if (m_upd_taken) begin
          m_ctr[i]   = hit ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
          m_valid[i] = 1;
          m_tag[i]   = tag_of(m_upd_pc);
          m_tgt[i]   = m_upd_tgt;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end
      m_upd = acc;
      if (acc) begin
        m_upd_pc = ex_if.pkt.pc; m_upd_tgt = ex_if.pkt.target_pc; m_upd_taken = ex_if.pkt.taken;
        m_br = m_br + 32'd1;
      end
      if (m_redir) begin
        if (redir_rdy) m_redir = 0;
      end else if (acc && !ex_if.pkt.pred_true) begin
        m_redir = 1; m_redir_pc = ex_if.pkt.target_pc; m_mis = m_mis + 32'd1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic [31:0] pc, input bit taken, input logic [31:0] tgt, input bit pred);
    ex_if.pkt.pc = pc; ex_if.pkt.taken = taken; ex_if.pkt.target_pc = tgt; ex_if.pkt.pred_true = pred;
  endtask

  task automatic check_all(input string t);
    chk({t, "_rdy"},       {31'd0, ex_if.rdy}, {31'd0, !m_redir});
    chk({t, "_redir_vld"}, {31'd0, redir_vld}, {31'd0, m_redir});
    chk({t, "_redir_pc"},  redir_pc,           m_redir_pc);
    chk({t, "_br_cnt"},    br_cnt,             m_br);
    chk({t, "_mis_cnt"},   mispred_cnt,        m_mis);
    chk({t, "_lk_taken"},  {31'd0, lk_taken},  {31'd0, exp_taken(lk_pc)});
    chk({t, "_lk_target"}, lk_target,          exp_target(lk_pc));
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0100;
      1: return 32'h0000_0140;
      2: return 32'h0000_0104;
      3: return 32'h0000_01C0;
      4: return 32'hFFFF_FFFC;
      default: return $urandom() & 32'h0000_0FFC;
    endcase
  endfunction

  initial begin
    rst = 1'b1; redir_rdy = 1'b0; lk_pc = 32'h100; ex_if.vld = 1'b0;
    set_pkt(32'd0, 1'b0, 32'd0, 1'b1);
    tick(); tick();
    check_all("reset");
    chk("rst_lk_taken",  {31'd0, lk_taken},  32'd0);
    chk("rst_lk_target", lk_target,          32'h104);
    chk("rst_rdy",       {31'd0, ex_if.rdy}, 32'd1);
    chk("rst_br_cnt",    br_cnt,             32'd0);
    rst = 1'b0;
    lk_pc = 32'hFFFF_FFFC; #1;
    chk("lk_wrap", lk_target, 32'd0);
    lk_pc = 32'h100;

    // mispredicted taken branch, redirect held off for three cycles
    set_pkt(32'h100, 1'b1, 32'h200, 1'b0); ex_if.vld = 1'b1;
    tick(); ex_if.vld = 1'b0;
    check_all("mis1");
    chk("mis1_redir_vld", {31'd0, redir_vld}, 32'd1);
    chk("mis1_redir_pc",  redir_pc,           32'h200);
    chk("mis1_rdy",       {31'd0, ex_if.rdy}, 32'd0);
    repeat (3) begin
      tick();
      check_all("hold");
      chk("hold_redir_pc", redir_pc, 32'h200);
    end
    redir_rdy = 1'b1; tick(); redir_rdy = 1'b0;
    check_all("hs1");
    chk("hs1_rdy",     {31'd0, ex_if.rdy}, 32'd1);
    chk("hs1_mis_cnt", mispred_cnt,        32'd1);
    chk("trained_taken",  {31'd0, lk_taken}, 32'd1);
    chk("trained_target", lk_target,         32'h200);

    // two not-taken resolves: ctr 10 -> 01 -> 00
    set_pkt(32'h100, 1'b0, 32'h104, 1'b1); ex_if.vld = 1'b1;
    tick(); check_all("nt1");
    set_pkt(32'h100, 1'b0, 32'h104, 1'b0);
    tick(); ex_if.vld = 1'b0; check_all("nt2");
    chk("nt2_redir_pc", redir_pc, 32'h104);
    redir_rdy = 1'b1; tick(); redir_rdy = 1'b0;
    check_all("nt_done");
    chk("nt_lk_taken", {31'd0, lk_taken}, 32'd0);

    // four taken (saturate at 11) then one not-taken -> 10
    ex_if.vld = 1'b1;
    repeat (4) begin
      set_pkt(32'h100, 1'b1, 32'h200, 1'b1);
      tick(); check_all("sat");
    end
    set_pkt(32'h100, 1'b0, 32'h104, 1'b1);
    tick(); ex_if.vld = 1'b0; tick();
    check_all("sat_dn");
    chk("sat_lk_taken", {31'd0, lk_taken}, 32'd1);

    // aliasing: 0x140 evicts 0x100 (same index, different tag)
    ex_if.vld = 1'b1;
    set_pkt(32'h100, 1'b1, 32'h200, 1'b1); tick();
    set_pkt(32'h140, 1'b1, 32'h300, 1'b1); tick();
    ex_if.vld = 1'b0; tick();
    check_all("alias");
    chk("alias_miss_target", lk_target, 32'h104);
    lk_pc = 32'h140; #1;
    chk("alias_new_taken",  {31'd0, lk_taken}, 32'd1);
    chk("alias_new_target", lk_target,         32'h300);

    // eight back-to-back correct predictions
    ex_if.vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_pkt(pick_pc(), 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, 1'b1);
      tick(); check_all("burst");
      chk("burst_no_redir", {31'd0, redir_vld}, 32'd0);
    end
    ex_if.vld = 1'b0;
    chk("burst_br_cnt", br_cnt, 32'd18);

    // reset while redirecting with an update pending
    set_pkt(32'h180, 1'b1, 32'h400, 1'b0); ex_if.vld = 1'b1;
    tick(); ex_if.vld = 1'b0;
    chk("pre_rst_redir", {31'd0, redir_vld}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_redir_vld", {31'd0, redir_vld}, 32'd0);
    tick();
    check_all("post_rst");
    for (int k = 0; k < 3; k++) begin
      lk_pc = 32'h100 + 32'h40 * k[31:0]; #1;
      chk("post_rst_lk_taken",  {31'd0, lk_taken}, 32'd0);
      chk("post_rst_lk_target", lk_target,         lk_pc + 32'd4);
    end

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 99) == 0);
      ex_if.vld = 1'($urandom_range(0, 1));
      redir_rdy = 1'($urandom_range(0, 1));
      set_pkt(pick_pc(), 1'($urandom_range(0, 1)), pick_pc(), ($urandom_range(0, 3) != 0));
      lk_pc = pick_pc();
      tick();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
